// File: rtl/mdu_unit_if.sv
// Handshake and data bundle between the pipeline EX stage and the multiply/divide unit.
interface mdu_unit_if;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] result;

    modport master (
        output SrcA, SrcB, MDUOp, start,
        input  busy, HI, LO, result
    );

    modport slave (
        input  SrcA, SrcB, MDUOp, start,
        output busy, HI, LO, result
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO; results are computed at accept time
// and committed after a fixed latency so timing matches a real iterative unit.
module mdu_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    mdu_unit_if.slave  bus
);
    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int          CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic [63:0]        mul_s_s;
    logic [63:0]        mul_u_s;
    logic [63:0]        div_res_s;
    logic [31:0]        result_s;

    // Magnitude divide then fix signs: avoids the INT_MIN/-1 overflow and a zero divisor.
    function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ua    = neg_a ? (32'd0 - a) : a;
        ub    = neg_b ? (32'd0 - b) : b;
        ub    = (ub == 32'd0) ? 32'd1 : ub;
        q     = ua / ub;
        r     = ua % ub;
        q     = (neg_a ^ neg_b) ? (32'd0 - q) : q;
        r     = neg_a ? (32'd0 - r) : r;
        return {r, q};
    endfunction

    // Operand datapath evaluated on the accepting cycle.
    always_comb begin
        mul_s_s   = {{32{bus.SrcA[31]}}, bus.SrcA} * {{32{bus.SrcB[31]}}, bus.SrcB};
        mul_u_s   = {32'h0, bus.SrcA} * {32'h0, bus.SrcB};
        div_res_s = div_calc(bus.SrcA, bus.SrcB, (bus.MDUOp == OP_DIV));
    end

    // Next-state, pending capture and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && ((bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU))) begin
                    pend_hi_d = (bus.MDUOp == OP_MULT) ? mul_s_s[63:32] : mul_u_s[63:32];
                    pend_lo_d = (bus.MDUOp == OP_MULT) ? mul_s_s[31:0]  : mul_u_s[31:0];
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MUL_CYCLES);
                    state_d   = ST_MUL;
                end else if (bus.start && ((bus.MDUOp == OP_DIV) || (bus.MDUOp == OP_DIVU))) begin
                    pend_hi_d = div_res_s[63:32];
                    pend_lo_d = div_res_s[31:0];
                    pend_wr_d = (bus.SrcB != 32'd0);
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    state_d   = ST_DIV;
                end else if (bus.MDUOp == OP_MTHI) begin
                    hi_d = bus.SrcA;
                end else if (bus.MDUOp == OP_MTLO) begin
                    lo_d = bus.SrcA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_wr_q ? pend_hi_q : hi_q;
                    lo_d    = pend_wr_q ? pend_lo_q : lo_q;
                    cnt_d   = CNT_W'(0);
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = CNT_W'(0);
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; reset also drops any pending result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_W'(0);
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
            pend_hi_q <= 32'h0;
            pend_lo_q <= 32'h0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // MFHI/MFLO read port.
    always_comb begin
        case (bus.MDUOp)
            OP_MFHI: result_s = hi_q;
            OP_MFLO: result_s = lo_q;
            default: result_s = 32'h0;
        endcase
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.result = result_s;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, arithmetic corner cases, ignored requests and reset abort.
module tb_mdu_unit;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   cyc;

    mdu_unit_if bus ();

    mdu_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse, scramble operands afterwards, and count busy cycles (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input string tag);
        bus.MDUOp = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            cyc++;
            step();
        end
        chk(tag, 32'(cyc), 32'(n));
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        bus.MDUOp = op;
        bus.SrcA  = a;
        step();
        bus.MDUOp = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        bus.SrcA  = 32'h0;
        bus.SrcB  = 32'h0;
        bus.MDUOp = 4'd0;
        bus.start = 1'b0;
        #12 reset_n = 1'b1;
        step(); step(); step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);
        chk("rst_result", bus.result, 32'h0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5, "mult_busy");
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 5, "multu_busy");
        chk("multu_hi", bus.HI, 32'h0000_0002);
        chk("multu_lo", bus.LO, 32'hFFFF_FFFA);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, "div_busy");
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);
        run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 10, "div_nd_busy");
        chk("div_nd_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_nd_hi", bus.HI, 32'h0000_0001);
        run_op(4'd4, 32'd100, 32'd7, 10, "divu_busy");
        chk("divu_lo", bus.LO, 32'd14);
        chk("divu_hi", bus.HI, 32'd2);
        mt(4'd7, 32'h11);
        mt(4'd8, 32'h22);
        run_op(4'd4, 32'd7, 32'd0, 10, "divz_busy");
        chk("divz_hi", bus.HI, 32'h11);
        chk("divz_lo", bus.LO, 32'h22);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, "divovf_busy");
        chk("divovf_lo", bus.LO, 32'h8000_0000);
        chk("divovf_hi", bus.HI, 32'h0);

        // MULT 2*3 with a second start and an MTHI arriving while busy
        bus.MDUOp = 4'd1;
        bus.SrcA  = 32'd2;
        bus.SrcB  = 32'd3;
        bus.start = 1'b1;
        step();
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            bus.start = (cyc == 1);
            bus.MDUOp = (cyc == 1) ? 4'd2 : ((cyc == 2) ? 4'd7 : 4'd0);
            bus.SrcA  = (cyc == 1) ? 32'd5 : 32'hAA;
            bus.SrcB  = 32'd5;
            cyc++;
            step();
        end
        bus.start = 1'b0;
        bus.MDUOp = 4'd0;
        chk("ign_busy", 32'(cyc), 32'd5);
        chk("ign_hi", bus.HI, 32'h0);
        chk("ign_lo", bus.LO, 32'd6);
        step();
        chk("ign_idle", 32'(bus.busy), 32'd0);

        mt(4'd8, 32'h1234);
        chk("mtlo_lo", bus.LO, 32'h1234);
        chk("mtlo_busy", 32'(bus.busy), 32'd0);
        bus.MDUOp = 4'd6;
        #1;
        chk("mflo", bus.result, 32'h1234);
        bus.MDUOp = 4'd5;
        #1;
        chk("mfhi", bus.result, 32'h0);
        bus.MDUOp = 4'd9;
        #1;
        chk("nop_result", bus.result, 32'h0);
        bus.MDUOp = 4'd0;

        mt(4'd7, 32'h55);
        bus.MDUOp = 4'd3;
        bus.SrcA  = 32'd100;
        bus.SrcB  = 32'd7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.MDUOp = 4'd0;
        step(); step(); step();
        chk("abort_pre_busy", 32'(bus.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.HI, 32'h0);
        chk("abort_lo", bus.LO, 32'h0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_hi", bus.HI, 32'h0);
        chk("post_lo", bus.LO, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
